// File: rtl/sdram_aref_timing.sv
// Periodic SDRAM auto-refresh generator: interval counter, arbiter request, PRECHARGE ALL + AUTO REFRESH burst.
// Optional sticky missed-deadline flag when SDRAM_AREF_OVERRUN_DET_EN is defined.
module sdram_aref_timing #(
   parameter int AREF_PERIOD = 780,
   parameter int T_RP        = 2,
   parameter int T_RFC       = 7,
   parameter int AREF_NUM    = 2
) (
   input  logic        sysclk_100M,
   input  logic        rst,
   input  logic        init_end_flag,
   input  logic        aref_en,
   output logic        aref_req,
   output logic        aref_end,
   output logic [3:0]  aref_cmd,
   output logic [1:0]  aref_ba,
   output logic [12:0] aref_addr,
`ifdef SDRAM_AREF_OVERRUN_DET_EN
   output logic        aref_overrun,
`endif
   output logic [2:0]  aref_state
);

   // Handshake: aref_req is held until the arbiter's aref_en is seen in IDLE;
   // the grant is consumed on that edge and the command burst follows.
   typedef enum logic [2:0] {
      S_IDLE, S_PCHG, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_DONE
   } state_t;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PCHG = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [9:0] CNT_LAST = 10'(AREF_PERIOD - 1);
   // Wait states last T-1 cycles, so the last wait index is T-2 (T_RP, T_RFC >= 2).
   localparam logic [7:0] RP_LAST  = 8'(T_RP - 2);
   localparam logic [7:0] RFC_LAST = 8'(T_RFC - 2);
   localparam logic [2:0] NUM      = 3'(AREF_NUM);

   state_t      state, state_next;
   logic [7:0]  wait_cnt, wait_next;
   logic [2:0]  issued, issued_next;
   logic [9:0]  cnt;
   logic        wrap, start;
   logic [3:0]  cmd_next;
   logic [1:0]  ba_next;
   logic [12:0] addr_next;
   logic        end_next;

   assign wrap       = init_end_flag && (cnt == CNT_LAST);
   assign start      = (state == S_IDLE) && aref_req && aref_en && init_end_flag;
   assign aref_state = state;

   always_ff @(posedge sysclk_100M or posedge rst) begin
      if (rst) begin
         cnt <= 10'd0;
      end else if (!init_end_flag || wrap) begin
         cnt <= 10'd0;
      end else begin
         cnt <= cnt + 10'd1;
      end
   end

   // A wrap coinciding with acceptance re-arms the request for the new interval.
   always_ff @(posedge sysclk_100M or posedge rst) begin
      if (rst) begin
         aref_req <= 1'b0;
      end else if (wrap) begin
         aref_req <= 1'b1;
      end else if (start) begin
         aref_req <= 1'b0;
      end
   end

`ifdef SDRAM_AREF_OVERRUN_DET_EN
   always_ff @(posedge sysclk_100M or posedge rst) begin
      if (rst) begin
         aref_overrun <= 1'b0;
      end else if (wrap && aref_req) begin
         aref_overrun <= 1'b1;
      end
   end
`endif

   always_ff @(posedge sysclk_100M or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= 8'd0;
         issued    <= 3'd0;
         aref_cmd  <= CMD_NOP;
         aref_ba   <= 2'b11;
         aref_addr <= 13'h1FFF;
         aref_end  <= 1'b0;
      end else begin
         state     <= state_next;
         wait_cnt  <= wait_next;
         issued    <= issued_next;
         aref_cmd  <= cmd_next;
         aref_ba   <= ba_next;
         aref_addr <= addr_next;
         aref_end  <= end_next;
      end
   end

   always_comb begin
      state_next  = state;
      wait_next   = wait_cnt;
      issued_next = issued;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_PCHG;
         end
         S_PCHG: begin
            state_next  = S_WAIT_RP;
            wait_next   = 8'd0;
            issued_next = 3'd0;
         end
         S_WAIT_RP: begin
            if (wait_cnt == RP_LAST) state_next = S_AREF;
            else                     wait_next  = wait_cnt + 8'd1;
         end
         S_AREF: begin
            state_next  = S_WAIT_RFC;
            wait_next   = 8'd0;
            issued_next = issued + 3'd1;
         end
         S_WAIT_RFC: begin
            if (wait_cnt == RFC_LAST) state_next = (issued < NUM) ? S_AREF : S_DONE;
            else                      wait_next  = wait_cnt + 8'd1;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_comb begin
      cmd_next  = CMD_NOP;
      ba_next   = 2'b11;
      addr_next = 13'h1FFF;
      end_next  = 1'b0;
      case (state_next)
         S_PCHG: begin
            cmd_next  = CMD_PCHG;
            ba_next   = 2'b00;
            addr_next = 13'h0400;
         end
         S_AREF: cmd_next = CMD_AREF;
         S_DONE: end_next = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_aref_timing.sv
// Self-checking bench for sdram_aref_timing: random grant/init stimulus against a
// schedule-based reference (sequence offsets computed arithmetically).
module tb_sdram_aref_timing;

   localparam int PERIOD  = 780;
   localparam int TRP     = 2;
   localparam int TRFC    = 7;
   localparam int NUM     = 2;
   localparam int SEQ_END = 1 + TRP + NUM * TRFC;
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_end_flag;
   logic        aref_en;
   logic        aref_req;
   logic        aref_end;
   logic [3:0]  aref_cmd;
   logic [1:0]  aref_ba;
   logic [12:0] aref_addr;
   logic [2:0]  aref_state;
`ifdef SDRAM_AREF_OVERRUN_DET_EN
   logic        aref_overrun;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdram_aref_timing #(
      .AREF_PERIOD(PERIOD), .T_RP(TRP), .T_RFC(TRFC), .AREF_NUM(NUM)
   ) dut (
      .sysclk_100M  (clk),
      .rst          (rst),
      .init_end_flag(init_end_flag),
      .aref_en      (aref_en),
      .aref_req     (aref_req),
      .aref_end     (aref_end),
      .aref_cmd     (aref_cmd),
      .aref_ba      (aref_ba),
      .aref_addr    (aref_addr),
`ifdef SDRAM_AREF_OVERRUN_DET_EN
      .aref_overrun (aref_overrun),
`endif
      .aref_state   (aref_state)
   );

   logic [20:0] obs;
   assign obs = {aref_req, aref_end, aref_cmd, aref_ba, aref_addr};

   // Reference: interval age, one pending flag, and the offset into a running sequence.
   int m_cnt, m_off;
   bit m_req, m_act, m_ovr, m_start, m_wrap;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_req = 0; m_act = 0; m_off = 0; m_ovr = 0;
      end else begin
         m_start = !m_act && m_req && aref_en && init_end_flag;
         m_wrap  = init_end_flag && (m_cnt == PERIOD - 1);
         if (m_wrap && m_req) m_ovr = 1;
         if (!init_end_flag || m_wrap) m_cnt = 0;
         else                          m_cnt = m_cnt + 1;
         if (m_wrap)       m_req = 1;
         else if (m_start) m_req = 0;
         if (m_start) begin
            m_act = 1; m_off = 1;
         end else if (m_act) begin
            if (m_off == SEQ_END) m_act = 0;
            else                  m_off = m_off + 1;
         end
      end
   end

   function automatic logic [20:0] model_vec();
      logic [3:0] c;
      int r;
      bit e;
      c = CMD_NOP;
      if (m_act) begin
         if (m_off == 1) c = CMD_PRE;
         else begin
            r = m_off - 1 - TRP;
            if (r >= 0 && (r % TRFC) == 0 && (r / TRFC) < NUM) c = CMD_AREF;
         end
      end
      e = m_act && (m_off == SEQ_END);
      return {m_req, e, c, (c == CMD_PRE) ? 2'b00 : 2'b11, (c == CMD_PRE) ? 13'h0400 : 13'h1FFF};
   endfunction

   task automatic test_reset();
      rst = 1'b1; init_end_flag = 1'b0; aref_en = 1'b0;
      #2;
      checks++;
      if (obs !== {1'b0, 1'b0, CMD_NOP, 2'b11, 13'h1FFF}) begin
         errors++; $display("FAIL reset_async obs=%h exp=%h", obs, {1'b0, 1'b0, CMD_NOP, 2'b11, 13'h1FFF});
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== {1'b0, 1'b0, CMD_NOP, 2'b11, 13'h1FFF}) begin
         errors++; $display("FAIL reset_held obs=%h exp=%h", obs, {1'b0, 1'b0, CMD_NOP, 2'b11, 13'h1FFF});
      end
      rst = 1'b0;
   endtask

   task automatic test_first_req();
      init_end_flag = 1'b1;
      for (int i = 1; i <= PERIOD + 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL first_req_model i=%0d obs=%h exp=%h", i, obs, model_vec());
         end
         checks++;
         if (aref_req !== (i >= PERIOD) || aref_cmd !== CMD_NOP) begin
            errors++; $display("FAIL first_req_edge i=%0d req=%b cmd=%b exp_req=%b", i, aref_req, aref_cmd, i >= PERIOD);
         end
      end
   endtask

   task automatic test_grant_sequence();
      int n;
      logic [3:0] lc;
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL grant_pre_model obs=%h exp=%h", obs, model_vec());
         end
      end
      aref_en = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk); #1;
         aref_en = 1'b0;
         lc = (k == 1) ? CMD_PRE : ((k == 3 || k == 10) ? CMD_AREF : CMD_NOP);
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL grant_model k=%0d obs=%h exp=%h", k, obs, model_vec());
         end
         checks++;
         if (aref_cmd !== lc || aref_end !== (k == 17) || aref_req !== 1'b0 ||
             (k == 1 && (aref_addr[10] !== 1'b1 || aref_ba !== 2'b00))) begin
            errors++; $display("FAIL grant_sched k=%0d cmd=%b end=%b req=%b exp_cmd=%b", k, aref_cmd, aref_end, aref_req, lc);
         end
      end
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < PERIOD + 20 && !m_req; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL %s_wait obs=%h exp=%h", name, obs, model_vec());
         end
      end
      checks++;
      if (aref_req !== 1'b1) begin
         errors++; $display("FAIL %s_timeout req=%b exp=1", name, aref_req);
      end
   endtask

   task automatic test_withhold();
      aref_en = 1'b0;
      wait_req("withhold");
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec() || aref_req !== 1'b1 || aref_cmd !== CMD_NOP) begin
            errors++; $display("FAIL withhold i=%0d obs=%h exp=%h", i, obs, model_vec());
         end
`ifdef SDRAM_AREF_OVERRUN_DET_EN
         checks++;
         if (aref_overrun !== m_ovr) begin
            errors++; $display("FAIL overrun i=%0d got=%b exp=%b", i, aref_overrun, m_ovr);
         end
`endif
      end
   endtask

   task automatic test_wrap_grant();
      for (int i = 0; i < PERIOD + 20 && m_cnt != PERIOD - 1; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL wrap_wait obs=%h exp=%h", obs, model_vec());
         end
      end
      aref_en = 1'b1;
      @(posedge clk); #1;
      aref_en = 1'b0;
      checks++;
      if (aref_req !== 1'b1 || aref_cmd !== CMD_PRE) begin
         errors++; $display("FAIL wrap_grant req=%b cmd=%b exp req=1 cmd=0010", aref_req, aref_cmd);
      end
      for (int k = 2; k <= 20; k++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL wrap_seq k=%0d obs=%h exp=%h", k, obs, model_vec());
         end
      end
      checks++;
      if (aref_req !== 1'b1) begin
         errors++; $display("FAIL wrap_req_after req=%b exp=1", aref_req);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2500; i++) begin
         aref_en       = ($urandom_range(0, 15) == 0);
         init_end_flag = ($urandom_range(0, 2999) != 0);
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, model_vec());
         end
      end
      aref_en = 1'b0;
      init_end_flag = 1'b1;
   endtask

   task automatic test_reset_mid();
      wait_req("rstmid");
      aref_en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         aref_en = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs !== {1'b0, 1'b0, CMD_NOP, 2'b11, 13'h1FFF}) begin
         errors++; $display("FAIL rstmid_async obs=%h exp=%h", obs, {1'b0, 1'b0, CMD_NOP, 2'b11, 13'h1FFF});
      end
      init_end_flag = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
      end
      init_end_flag = 1'b1;
      for (int i = 1; i <= PERIOD + 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obs !== model_vec() || aref_req !== (i >= PERIOD) || aref_cmd !== CMD_NOP) begin
            errors++; $display("FAIL rstmid_after i=%0d obs=%h exp=%h", i, obs, model_vec());
         end
      end
   endtask

   task automatic test_init_drop();
      logic [3:0] lc;
      wait_req("initdrop");
      aref_en = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk); #1;
         aref_en = 1'b0;
         if (k == 3) init_end_flag = 1'b0;
         lc = (k == 1) ? CMD_PRE : ((k == 3 || k == 10) ? CMD_AREF : CMD_NOP);
         checks++;
         if (aref_cmd !== lc || aref_end !== (k == 17) || obs !== model_vec()) begin
            errors++; $display("FAIL initdrop_seq k=%0d cmd=%b end=%b exp_cmd=%b", k, aref_cmd, aref_end, lc);
         end
      end
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         checks++;
         if (aref_req !== 1'b0 || aref_cmd !== CMD_NOP || obs !== model_vec()) begin
            errors++; $display("FAIL initdrop_idle i=%0d obs=%h exp=%h", i, obs, model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_req();
      test_grant_sequence();
      test_withhold();
      test_wrap_grant();
      test_random();
      test_reset_mid();
      test_init_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
